// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite path: position width, FSM encoding and the
// per-axis bounce function used by sprite_mover.
package sprite_pkg;

    localparam int POS_W    = 10;
    localparam int WD_W     = 22;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ARMED = 2'd2
    } state_t;

    typedef struct packed {
        logic [POS_W-1:0] pos;
        logic             dir;
        logic             hit;
    } axis_t;

    // One axis move; arithmetic is one bit wider than the position so it cannot wrap.
    function automatic axis_t axis_step(input logic [POS_W-1:0] pos,
                                        input logic             dir,
                                        input logic [POS_W:0]   lim,
                                        input logic [POS_W:0]   stp);
        axis_t            res;
        logic [POS_W:0]   wide;
        logic [POS_W:0]   sum;
        logic [POS_W:0]   diff;
        wide     = {1'b0, pos};
        sum      = wide + stp;
        diff     = wide - stp;
        res.pos  = pos;
        res.dir  = dir;
        res.hit  = 1'b0;
        if (dir) begin
            if (sum >= lim) begin
                res.pos = lim[POS_W-1:0];
                res.dir = 1'b0;
                res.hit = 1'b1;
            end else begin
                res.pos = sum[POS_W-1:0];
            end
        end else begin
            if (wide <= stp) begin
                res.pos = '0;
                res.dir = 1'b1;
                res.hit = 1'b1;
            end else begin
                res.pos = diff[POS_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/tick_watchdog.sv
// Saturating cycle counter with a sticky flag, raised when the tick stream
// has been absent for TIMEOUT cycles while the mover is active.
module tick_watchdog
    import sprite_pkg::*;
#(
    parameter int TIMEOUT = 3_400_000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    output logic o_tick_lost
);

    localparam logic [WD_W-1:0] LIMIT = TIMEOUT[WD_W-1:0];

    logic [WD_W-1:0] r_cnt;
    logic            r_lost;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_lost <= 1'b0;
        end else begin
            if (i_clear) begin
                r_cnt <= '0;
            end else if (r_cnt != {WD_W{1'b1}}) begin
                r_cnt <= r_cnt + 1'b1;
            end
            // The flag survives counter clears; only reset removes it.
            if (r_cnt >= LIMIT) begin
                r_lost <= 1'b1;
            end
        end
    end

    assign o_tick_lost = r_lost;

endmodule

// File: rtl/sprite_mover.sv
// Advances a sprite's top-left corner on qualified frame ticks and bounces it
// off the active-area edges. Optional watchdog: SPRITE_MOVER_TICK_WATCHDOG_EN.
module sprite_mover
    import sprite_pkg::*;
#(
    parameter int H_ACTIVE     = sprite_pkg::H_ACTIVE,
    parameter int V_ACTIVE     = sprite_pkg::V_ACTIVE,
    parameter int SPR_W        = 16,
    parameter int SPR_H        = 16,
    parameter int STEP         = 2,
    parameter int X_INIT       = 0,
    parameter int Y_INIT       = 0,
    parameter int TICK_TIMEOUT = 3_400_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             run,
    input  logic             step,
    output logic [POS_W-1:0] x_pos,
    output logic [POS_W-1:0] y_pos,
    output logic             dir_x,
    output logic             dir_y,
    output logic             bounce,
    output logic             tick_lost
);

    localparam int XMAX_I = H_ACTIVE - SPR_W;
    localparam int YMAX_I = V_ACTIVE - SPR_H;
    localparam logic [POS_W:0]   XMAX  = XMAX_I[POS_W:0];
    localparam logic [POS_W:0]   YMAX  = YMAX_I[POS_W:0];
    localparam logic [POS_W:0]   STP   = STEP[POS_W:0];
    localparam logic [POS_W-1:0] X_RST = X_INIT[POS_W-1:0];
    localparam logic [POS_W-1:0] Y_RST = Y_INIT[POS_W-1:0];

    state_t           r_state;
    state_t           w_state_next;
    logic             w_move;
    axis_t            w_ax;
    axis_t            w_ay;
    logic [POS_W-1:0] r_x;
    logic [POS_W-1:0] r_y;
    logic             r_dir_x;
    logic             r_dir_y;
    logic             r_bounce;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Move qualification uses the current state, so a tick alongside run rising is ignored.
    always_comb begin
        w_state_next = r_state;
        w_move       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (run) begin
                    w_state_next = ST_RUN;
                end else if (step) begin
                    w_state_next = ST_ARMED;
                end
            end
            ST_RUN: begin
                w_move = tick;
                if (!run) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_ARMED: begin
                w_move = tick;
                if (tick) begin
                    w_state_next = ST_IDLE;
                end else if (run) begin
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_ax = axis_step(r_x, r_dir_x, XMAX, STP);
    assign w_ay = axis_step(r_y, r_dir_y, YMAX, STP);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_x      <= X_RST;
            r_y      <= Y_RST;
            r_dir_x  <= 1'b1;
            r_dir_y  <= 1'b1;
            r_bounce <= 1'b0;
        end else if (w_move) begin
            r_x      <= w_ax.pos;
            r_y      <= w_ay.pos;
            r_dir_x  <= w_ax.dir;
            r_dir_y  <= w_ay.dir;
            r_bounce <= w_ax.hit | w_ay.hit;
        end else begin
            r_bounce <= 1'b0;
        end
    end

    assign x_pos  = r_x;
    assign y_pos  = r_y;
    assign dir_x  = r_dir_x;
    assign dir_y  = r_dir_y;
    assign bounce = r_bounce;

`ifdef SPRITE_MOVER_TICK_WATCHDOG_EN
    logic w_wd_clear;
    assign w_wd_clear = tick | (r_state == ST_IDLE);

    tick_watchdog #(
        .TIMEOUT (TICK_TIMEOUT)
    ) u_tick_watchdog (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (w_wd_clear),
        .o_tick_lost (tick_lost)
    );
`else
    assign tick_lost = 1'b0;
`endif

endmodule
